// File: rtl/psum_ofifo_pkg.sv
// ----------------------------------------------------------------------------
// psum_ofifo_pkg
//   Shared constants and helpers for the partial-sum output FIFO stage.
//   PSUM_BW     : width of one partial sum
//   COL         : number of MAC columns (one FIFO each)
//   OFIFO_DEPTH : entries per column FIFO (power of 2, >= 4)
//   clog2()     : elaboration-time log2 for pointer sizing
//   ofifo_err_t : sticky error flags reported by the top
// ----------------------------------------------------------------------------
package psum_ofifo_pkg;

   localparam int PSUM_BW     = 16;
   localparam int COL         = 8;
   localparam int OFIFO_DEPTH = 64;

   // Smallest r with 2**r >= v.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   typedef struct packed {
      logic ovf;   // a write hit a full column
      logic udf;   // rd asserted with no complete row available
   } ofifo_err_t;

endpackage

// File: rtl/psum_fifo_col.sv
// ----------------------------------------------------------------------------
// psum_fifo_col
//   Single-column synchronous FIFO holding partial sums for one MAC column.
//   Ports:
//     clk, reset : rising-edge clock, synchronous active-high reset
//     wr         : push in (ignored while full)
//     rd         : pop head (ignored while empty)
//     in         : data to push
//     out_head   : current head entry (combinational, valid when !empty)
//     empty/full : occupancy status from the current pointers
// ----------------------------------------------------------------------------
module psum_fifo_col
   import psum_ofifo_pkg::*;
#(
   parameter int width = PSUM_BW,
   parameter int depth = OFIFO_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic             rd,
   input  logic [width-1:0] in,
   output logic [width-1:0] out_head,
   output logic             empty,
   output logic             full
);

   localparam int AW = clog2(depth);

   // One extra MSB per pointer so full and empty are distinguishable when
   // the index bits match; pointers wrap modulo 2*depth.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [width-1:0] mem [depth];
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Fullness is judged before the edge: a write into a full column is
   // dropped even when a pop frees a slot on the same edge.
   assign wr_en = wr & ~full;
   assign rd_en = rd & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_ptr[AW-1:0]] <= in;
   end

   assign out_head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/psum_ofifo.sv
// ----------------------------------------------------------------------------
// psum_ofifo
//   Output collection stage behind the MAC row array. Each column captures
//   its partial sum on its own (skewed) valid strobe into a private FIFO;
//   a full row is popped across all columns at once when every column has
//   data.
//   Ports:
//     clk, reset : rising-edge clock, synchronous active-high reset
//     wr[col]    : per-column write strobe (MAC valid[i])
//     in         : partial sums, column i at [psum_bw*(i+1)-1 : psum_bw*i]
//     rd         : pop one aligned row
//     out        : registered popped row, same packing as in
//     o_valid    : one-cycle pulse, out holds a freshly popped row
//     o_ready    : every column non-empty
//     o_full     : any column full
//     o_ovf      : sticky, a write was dropped on a full column
//     o_udf      : sticky, rd asserted while o_ready was low
// ----------------------------------------------------------------------------
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = OFIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col-1:0]         wr,
   input  logic [psum_bw*col-1:0] in,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_valid,
   output logic                   o_ready,
   output logic                   o_full,
   output logic                   o_ovf,
   output logic                   o_udf
);

   logic [col-1:0]              empty;
   logic [col-1:0]              full;
   logic [psum_bw*col-1:0]      head;
   logic [col-1:0][psum_bw-1:0] out_q;
   logic                        pop;
   logic                        valid_q;
   ofifo_err_t                  err_q;

   // All columns pop together, so every instance sees the same gated rd.
   psum_fifo_col #(
      .width (psum_bw),
      .depth (depth)
   ) u_col [col-1:0] (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .rd       ({col{pop}}),
      .in       (in),
      .out_head (head),
      .empty    (empty),
      .full     (full)
   );

   assign o_ready = &(~empty);
   assign o_full  = |full;
   assign pop     = rd & o_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= '0;
      end else begin
         valid_q   <= pop;
         // out is held (not cleared) on cycles without a pop.
         if (pop) out_q <= head;
         err_q.ovf <= err_q.ovf | (|(wr & full));
         err_q.udf <= err_q.udf | (rd & ~o_ready);
      end
   end

   assign out     = out_q;
   assign o_valid = valid_q;
   assign o_ovf   = err_q.ovf;
   assign o_udf   = err_q.udf;

endmodule

// File: tb/tb_psum_ofifo.sv
// ----------------------------------------------------------------------------
// tb_psum_ofifo
//   Self-checking bench for psum_ofifo (col=8, psum_bw=16, depth=64).
//   A directed vector table covers reset, underflow and the skewed fill;
//   hand-written sequences cover streaming, overflow, pointer wrap and
//   reset in the middle of traffic. A per-column queue model is checked
//   every cycle alongside the hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_psum_ofifo;

   localparam int NC = 8;
   localparam int BW = 16;
   localparam int DP = 64;

   logic              clk;
   logic              reset;
   logic [NC-1:0]     wr;
   logic [NC*BW-1:0]  in;
   logic              rd;
   logic [NC*BW-1:0]  out;
   logic              o_valid;
   logic              o_ready;
   logic              o_full;
   logic              o_ovf;
   logic              o_udf;

   psum_ofifo #(.col(NC), .psum_bw(BW), .depth(DP)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .in      (in),
      .rd      (rd),
      .out     (out),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_full  (o_full),
      .o_ovf   (o_ovf),
      .o_udf   (o_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: one queue per column plus flags.
   logic [BW-1:0]    mq [NC][$];
   logic [NC*BW-1:0] m_out;
   logic             m_valid;
   logic             m_ovf;
   logic             m_udf;

   task automatic chk(input string name, input logic [NC*BW-1:0] act, input logic [NC*BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic m_ready();
      logic r;
      r = 1'b1;
      for (int i = 0; i < NC; i++) if (mq[i].size() == 0) r = 1'b0;
      return r;
   endfunction

   function automatic logic m_full();
      logic f;
      f = 1'b0;
      for (int i = 0; i < NC; i++) if (mq[i].size() == DP) f = 1'b1;
      return f;
   endfunction

   // Drive one cycle of inputs, advance the model, clock, then compare.
   task automatic cycle(input logic rst, input logic [NC-1:0] w, input logic [NC*BW-1:0] d, input logic r);
      logic          rdy;
      logic [NC-1:0] pre_full;
      reset = rst; wr = w; in = d; rd = r;
      rdy = m_ready();
      for (int i = 0; i < NC; i++) pre_full[i] = (mq[i].size() == DP);
      if (rst) begin
         for (int i = 0; i < NC; i++) mq[i].delete();
         m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         m_valid = r & rdy;
         if (r && !rdy) m_udf = 1'b1;
         if (m_valid) for (int i = 0; i < NC; i++) m_out[i*BW +: BW] = mq[i].pop_front();
         for (int i = 0; i < NC; i++) begin
            if (w[i]) begin
               if (pre_full[i]) m_ovf = 1'b1;
               else mq[i].push_back(d[i*BW +: BW]);
            end
         end
      end
      @(posedge clk); #1;
      cyc++;
      chk("valid", {127'd0, o_valid}, {127'd0, m_valid});
      chk("out",   out, m_out);
      chk("ready", {127'd0, o_ready}, {127'd0, m_ready()});
      chk("full",  {127'd0, o_full},  {127'd0, m_full()});
      chk("ovf",   {127'd0, o_ovf},   {127'd0, m_ovf});
      chk("udf",   {127'd0, o_udf},   {127'd0, m_udf});
   endtask

   typedef struct {
      logic             rst;
      logic [NC-1:0]    w;
      logic [NC*BW-1:0] d;
      logic             r;
      logic             e_ready;
      logic             e_valid;
      logic             e_udf;
      logic [NC*BW-1:0] e_out;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic [NC*BW-1:0] row;
      logic [NC*BW-1:0] d;
      reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
      m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

      // ---------------- vector table: reset, underflow, skewed fill ------
      row = '0;
      for (int i = 0; i < NC; i++) row[i*BW +: BW] = 16'h0100 + 16'(i);
      tbl[0] = '{rst:1, w:'0, d:'0, r:0, e_ready:0, e_valid:0, e_udf:0, e_out:'0};
      tbl[1] = '{rst:0, w:'0, d:'0, r:1, e_ready:0, e_valid:0, e_udf:1, e_out:'0};
      for (int i = 0; i < NC; i++) begin
         d = '0;
         d[i*BW +: BW] = 16'h0100 + 16'(i);
         tbl[2+i] = '{rst:0, w:8'(1 << i), d:d, r:0, e_ready:(i == NC-1), e_valid:0, e_udf:1, e_out:'0};
      end
      tbl[10] = '{rst:0, w:'0, d:'0, r:1, e_ready:0, e_valid:1, e_udf:1, e_out:row};
      tbl[11] = '{rst:0, w:'0, d:'0, r:0, e_ready:0, e_valid:0, e_udf:1, e_out:row};
      tbl[12] = '{rst:1, w:'0, d:'0, r:0, e_ready:0, e_valid:0, e_udf:0, e_out:'0};

      for (int k = 0; k < 13; k++) begin
         cycle(tbl[k].rst, tbl[k].w, tbl[k].d, tbl[k].r);
         chk("tbl_ready", {127'd0, o_ready}, {127'd0, tbl[k].e_ready});
         chk("tbl_valid", {127'd0, o_valid}, {127'd0, tbl[k].e_valid});
         chk("tbl_udf",   {127'd0, o_udf},   {127'd0, tbl[k].e_udf});
         chk("tbl_out",   out, tbl[k].e_out);
      end

      // ---------------- streaming: 100 rows, pop from cycle 2 ------------
      for (int c = 0; c < 100; c++) begin
         for (int i = 0; i < NC; i++) d[i*BW +: BW] = 16'(c * 16 + i);
         cycle(1'b0, 8'hFF, d, (c >= 2));
      end
      for (int k = 0; k < 8 && m_ready(); k++) cycle(1'b0, '0, '0, 1'b1);
      chk("stream_empty", {127'd0, o_ready}, 128'd0);
      chk("stream_ovf",   {127'd0, o_ovf},   128'd0);
      chk("stream_udf",   {127'd0, o_udf},   128'd0);

      // ---------------- full / overflow on column 3 ----------------------
      cycle(1'b1, '0, '0, 1'b0);
      for (int k = 0; k < 65; k++) begin
         d = '0;
         d[3*BW +: BW] = 16'(k);
         cycle(1'b0, 8'h08, d, 1'b0);
         if (k == 63) begin
            chk("full_at64", {127'd0, o_full}, 128'd1);
            chk("no_ovf_64", {127'd0, o_ovf},  128'd0);
         end
      end
      chk("ovf_at65", {127'd0, o_ovf}, 128'd1);
      for (int k = 0; k < 64; k++) begin
         for (int i = 0; i < NC; i++) d[i*BW +: BW] = 16'h5000 + 16'(k);
         cycle(1'b0, 8'hF7, d, 1'b0);
      end
      for (int k = 0; k < 64; k++) begin
         cycle(1'b0, '0, '0, 1'b1);
         chk("col3_data", {112'd0, out[3*BW +: BW]}, {112'd0, 16'(k)});
      end
      chk("ovf_drained", {127'd0, o_ready}, 128'd0);

      // ---------------- pointer wrap: 40 in/out twice --------------------
      cycle(1'b1, '0, '0, 1'b0);
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NC; i++) d[i*BW +: BW] = 16'h2000 + 16'(p * 1024 + k * 8 + i);
            cycle(1'b0, 8'hFF, d, 1'b0);
         end
         for (int k = 0; k < 40; k++) cycle(1'b0, '0, '0, 1'b1);
      end
      chk("wrap_empty", {127'd0, o_ready}, 128'd0);
      chk("wrap_full",  {127'd0, o_full},  128'd0);
      // One fresh row must come straight back: proves no column had residue.
      for (int i = 0; i < NC; i++) d[i*BW +: BW] = 16'hA0A0 + 16'(i);
      cycle(1'b0, 8'hFF, d, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      chk("wrap_probe", out, d);

      // ---------------- reset mid-operation ------------------------------
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < NC; i++) d[i*BW +: BW] = 16'h7000 + 16'(k * 8 + i);
         cycle(1'b0, 8'hFF, d, 1'b0);
      end
      for (int i = 0; i < NC; i++) d[i*BW +: BW] = 16'hDEAD;
      cycle(1'b1, 8'hFF, d, 1'b1);
      chk("rst_out",   out, '0);
      chk("rst_valid", {127'd0, o_valid}, 128'd0);
      chk("rst_ready", {127'd0, o_ready}, 128'd0);
      cycle(1'b0, '0, '0, 1'b0);
      chk("rst_nowrite", {127'd0, o_ready}, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
